// File: rtl/alu_pkg.sv
// Shared op-code constants, default width and FSM state type for the execute-stage ALU.
package alu_pkg;

  localparam int ALU_XLEN = 32;

  // Op codes shared with the ALU control decoder.
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0100;
  localparam logic [3:0] ALU_SRA = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } alu_state_e;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// Iterative 1-bit/cycle shifter: accumulator plus down-counter of remaining steps.
module alu_shift_iter #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            dir,
  input  logic            arith,
  input  logic [SHW-1:0]  amount,
  input  logic [XLEN-1:0] din,
  output logic            done,
  output logic [XLEN-1:0] value
);

  logic [XLEN-1:0] acc;
  logic [SHW-1:0]  cnt;
  logic            dir_q;
  logic            arith_q;
  logic [XLEN-1:0] step;

  always_comb begin
    if (dir_q) step = {arith_q & acc[XLEN-1], acc[XLEN-1:1]};
    else       step = {acc[XLEN-2:0], 1'b0};
  end

  // value is one step ahead so the caller can register it on the last count.
  assign done  = (cnt == SHW'(1));
  assign value = step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      cnt     <= '0;
      dir_q   <= 1'b0;
      arith_q <= 1'b0;
    end else if (load) begin
      acc     <= din;
      cnt     <= amount;
      dir_q   <= dir;
      arith_q <= arith;
    end else if (cnt != '0) begin
      acc <= step;
      cnt <= cnt - SHW'(1);
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith ops, iterative shifts, valid/ready on both sides.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int N    = 4,
  parameter int XLEN = ALU_XLEN,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    alu_operation,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal_op
);

  alu_state_e      state, state_nxt;
  logic            accept;
  logic            op_shift;
  logic [SHW-1:0]  amt;
  logic            long_shift;
  logic [XLEN-1:0] alu_res;
  logic            alu_ill;
  logic            shift_load;
  logic            res_load;
  logic            res_from_shift;
  logic            sh_done;
  logic [XLEN-1:0] sh_value;

  assign op_shift   = is_shift_op(alu_operation);
  assign amt        = operand_b[SHW-1:0];
  assign long_shift = op_shift && (amt != '0);
  assign accept     = in_valid && in_ready;

  // Single-cycle datapath; a zero-amount shift falls through as a plain copy of operand_a.
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (alu_operation)
      ALU_AND: alu_res = operand_a & operand_b;
      ALU_OR:  alu_res = operand_a | operand_b;
      ALU_ADD: alu_res = operand_a + operand_b;
      ALU_SUB: alu_res = operand_a - operand_b;
      ALU_SLT: alu_res = {{(XLEN-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
      ALU_NOR: alu_res = ~(operand_a | operand_b);
      ALU_SLL, ALU_SRL, ALU_SRA: alu_res = operand_a;
      default: alu_ill = 1'b1;
    endcase
  end

  alu_shift_iter #(
    .XLEN (XLEN),
    .SHW  (SHW)
  ) u_shift (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (shift_load),
    .dir    (alu_operation != ALU_SLL),
    .arith  (alu_operation == ALU_SRA),
    .amount (amt),
    .din    (operand_a),
    .done   (sh_done),
    .value  (sh_value)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, HOLD: begin
        if (accept)                       state_nxt = long_shift ? SHIFT : HOLD;
        else if (state == HOLD && !out_ready) state_nxt = HOLD;
        else                              state_nxt = IDLE;
      end
      SHIFT:   if (sh_done) state_nxt = HOLD;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready       = (state == IDLE) || (state == HOLD && out_ready);
    shift_load     = 1'b0;
    res_load       = 1'b0;
    res_from_shift = 1'b0;
    if (state == SHIFT) begin
      res_load       = sh_done;
      res_from_shift = 1'b1;
    end else if (accept) begin
      shift_load = long_shift;
      res_load   = !long_shift;
    end
  end

  assign out_valid = (state == HOLD);

  // Output registers only move on a load, so they stay put while HOLD is back-pressured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result     <= '0;
      zero       <= 1'b0;
      illegal_op <= 1'b0;
    end else if (res_load) begin
      if (res_from_shift) begin
        result     <= sh_value;
        zero       <= (sh_value == '0);
        illegal_op <= 1'b0;
      end else begin
        result     <= alu_res;
        zero       <= (alu_res == '0);
        illegal_op <= alu_ill;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: vector table plus backpressure, back-to-back and reset sequences.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_operation;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal_op;

  int checks   = 0;
  int failures = 0;

  alu_exec_unit #(.N(4), .XLEN(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .alu_operation (alu_operation),
    .operand_a     (operand_a),
    .operand_b     (operand_b),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .result        (result),
    .zero          (zero),
    .illegal_op    (illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{4'b0010, 32'd5,         32'd7,         32'd12,        1'b0, 1'b0, 1};
    vecs[1]  = '{4'b0110, 32'd9,         32'd9,         32'd0,         1'b1, 1'b0, 1};
    vecs[2]  = '{4'b0000, 32'hF0,        32'h0F,        32'h0,         1'b1, 1'b0, 1};
    vecs[3]  = '{4'b0001, 32'hF0,        32'h0F,        32'hFF,        1'b0, 1'b0, 1};
    vecs[4]  = '{4'b0111, 32'hFFFFFFFF,  32'd1,         32'd1,         1'b0, 1'b0, 1};
    vecs[5]  = '{4'b0111, 32'd1,         32'hFFFFFFFF,  32'd0,         1'b1, 1'b0, 1};
    vecs[6]  = '{4'b1100, 32'h0,         32'h0,         32'hFFFFFFFF,  1'b0, 1'b0, 1};
    vecs[7]  = '{4'b0010, 32'hFFFFFFFF,  32'd1,         32'd0,         1'b1, 1'b0, 1};
    vecs[8]  = '{4'b0110, 32'd0,         32'd1,         32'hFFFFFFFF,  1'b0, 1'b0, 1};
    vecs[9]  = '{4'b0101, 32'h80000000,  32'd4,         32'hF8000000,  1'b0, 1'b0, 5};
    vecs[10] = '{4'b0011, 32'h1234,      32'd0,         32'h1234,      1'b0, 1'b0, 1};
    vecs[11] = '{4'b0011, 32'h1,         32'd31,        32'h80000000,  1'b0, 1'b0, 32};
    vecs[12] = '{4'b0100, 32'h80000000,  32'd31,        32'h1,         1'b0, 1'b0, 32};
    vecs[13] = '{4'b0101, 32'h7FFFFFF0,  32'd4,         32'h07FFFFFF,  1'b0, 1'b0, 5};
    vecs[14] = '{4'b1111, 32'd3,         32'd4,         32'd0,         1'b1, 1'b1, 1};
    vecs[15] = '{4'b0010, 32'd1,         32'd2,         32'd3,         1'b0, 1'b0, 1};
    vecs[16] = '{4'b0100, 32'hF0,        32'h25,        32'h7,         1'b0, 1'b0, 6};
    vecs[17] = '{4'b1000, 32'h55,        32'h66,        32'd0,         1'b1, 1'b1, 1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_operation = '0; operand_a = '0; operand_b = '0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    chk("rst_illegal", 32'(illegal_op), 32'd0);
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Table-driven single requests, including latency and busy in_ready.
    foreach (vecs[i]) begin
      int cycles;
      int bad;
      alu_operation = vecs[i].op; operand_a = vecs[i].a; operand_b = vecs[i].b;
      in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      operand_a = 32'hDEADBEEF; operand_b = 32'h3;
      cycles = 1; bad = 0;
      while (!out_valid && cycles < 40) begin
        if (in_ready) bad++;
        step();
        cycles++;
      end
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d_latency", i), 32'(cycles), 32'(vecs[i].lat));
      chk($sformatf("v%0d_busy_ready", i), 32'(bad), 32'd0);
      chk($sformatf("v%0d_result", i), result, vecs[i].res);
      chk($sformatf("v%0d_zero", i), 32'(zero), 32'(vecs[i].z));
      chk($sformatf("v%0d_illegal", i), 32'(illegal_op), 32'(vecs[i].ill));
    end
    step();
    chk("drain_out_valid", 32'(out_valid), 32'd0);

    // Backpressure: result must hold steady for three stalled cycles.
    out_ready = 1'b0;
    alu_operation = 4'b0010; operand_a = 32'd2; operand_b = 32'd3; in_valid = 1'b1;
    step();
    in_valid = 1'b0; operand_a = 32'd100;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp%0d_out_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("bp%0d_result", k), result, 32'd5);
      chk($sformatf("bp%0d_in_ready", k), 32'(in_ready), 32'd0);
      if (k < 2) step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_ready_release", 32'(in_ready), 32'd1);
    step();
    chk("bp_out_valid_drop", 32'(out_valid), 32'd0);
    chk("bp_in_ready_idle", 32'(in_ready), 32'd1);

    // Back-to-back single-cycle ops at one per cycle.
    out_ready = 1'b1; in_valid = 1'b1;
    alu_operation = 4'b0001; operand_a = 32'hF0; operand_b = 32'h0F;
    step();
    chk("b2b_or_valid", 32'(out_valid), 32'd1);
    chk("b2b_or_result", result, 32'hFF);
    chk("b2b_or_ready", 32'(in_ready), 32'd1);
    alu_operation = 4'b0000;
    step();
    chk("b2b_and_valid", 32'(out_valid), 32'd1);
    chk("b2b_and_result", result, 32'h0);
    chk("b2b_and_zero", 32'(zero), 32'd1);
    alu_operation = 4'b0111; operand_a = 32'hFFFFFFFF; operand_b = 32'd1;
    step();
    chk("b2b_slt_valid", 32'(out_valid), 32'd1);
    chk("b2b_slt_result", result, 32'd1);
    chk("b2b_slt_zero", 32'(zero), 32'd0);
    in_valid = 1'b0;
    step();
    chk("b2b_end_valid", 32'(out_valid), 32'd0);

    // Reset in the middle of a long shift.
    alu_operation = 4'b0100; operand_a = 32'hFFFFFFFF; operand_b = 32'd20; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("mid_shift_ready", 32'(in_ready), 32'd0);
    chk("mid_shift_valid", 32'(out_valid), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_result", result, 32'd0);
    chk("rst_mid_zero", 32'(zero), 32'd0);
    chk("rst_mid_illegal", 32'(illegal_op), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 25; k++) step();
    chk("post_rst_no_stale", 32'(out_valid), 32'd0);
    alu_operation = 4'b0010; operand_a = 32'd10; operand_b = 32'd20; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("post_rst_add_valid", 32'(out_valid), 32'd1);
    chk("post_rst_add_result", result, 32'd30);
    chk("post_rst_add_zero", 32'(zero), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
